// File: rtl/adder_simd_pipe_pkg.sv
// Shared types and lane-partition helpers for the SIMD adder.
// Segment count is fixed at four; helpers decode lane boundaries from the mode.
package adder_simd_pipe_pkg;

  localparam int unsigned SEG_COUNT_FIXED = 4;

  typedef enum logic [1:0] {
    LM_X1   = 2'd0,
    LM_X2   = 2'd1,
    LM_X4   = 2'd2,
    LM_RSVD = 2'd3
  } lane_mode_e;

  // Segment starts a lane (takes the lane carry-in instead of the chained carry).
  function automatic logic lane_start(lane_mode_e mode, int unsigned seg);
    logic start;
    case (mode)
      LM_X2:   start = (seg % 2) == 0;
      LM_X4:   start = 1'b1;
      default: start = (seg == 0);
    endcase
    return start;
  endfunction

  // Segment is the most significant segment of its lane.
  function automatic logic lane_top(lane_mode_e mode, int unsigned seg);
    logic top;
    case (mode)
      LM_X2:   top = (seg % 2) == 1;
      LM_X4:   top = 1'b1;
      default: top = (seg == SEG_COUNT_FIXED - 1);
    endcase
    return top;
  endfunction

endpackage

// File: rtl/adder_simd_pipe_if.sv
// Valid/ready transaction bundle for the partitioned SIMD adder.
interface adder_simd_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEG_COUNT  = 4
) ();

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            a;
  logic [DATA_WIDTH-1:0]            b;
  logic                             cin;
  logic                             op_sub;
  adder_simd_pipe_pkg::lane_mode_e  lane_mode;
  logic                             is_signed;
  logic                             sat_en;

  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            sum;
  logic [SEG_COUNT-1:0]             cout;
  logic [SEG_COUNT-1:0]             ovf;
  logic                             sat_hit;
  logic                             mode_err;

  modport master (
    output in_valid, a, b, cin, op_sub, lane_mode, is_signed, sat_en, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, sat_hit, mode_err
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, lane_mode, is_signed, sat_en, out_ready,
    output in_ready, out_valid, sum, cout, ovf, sat_hit, mode_err
  );

endinterface

// File: rtl/adder_simd_seg.sv
// One combinational segment slice: a + (inv_b ? ~b : b) + cin with carry-out in the MSB.
module adder_simd_seg #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             inv_b,
  input  logic             cin,
  output logic [SEG_W:0]   sum_ext
);

  logic [SEG_W-1:0] b_eff;

  always_comb begin
    b_eff   = inv_b ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{SEG_W{1'b0}}, cin};
  end

endmodule

// File: rtl/adder_simd_pipe.sv
// Two-stage SIMD add/subtract: stage 1 runs the lane-partitioned carry chain,
// stage 2 derives per-lane carry/overflow flags and applies saturation.
module adder_simd_pipe
  import adder_simd_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEG_COUNT  = 4
) (
  input logic              clk,
  input logic              rst,
  adder_simd_pipe_if.slave bus
);

  localparam int unsigned SEG_W = DATA_WIDTH / SEG_COUNT;

  if (SEG_COUNT != SEG_COUNT_FIXED) begin : g_bad_seg_count
    $fatal(1, "adder_simd_pipe: SEG_COUNT must be 4");
  end
  if ((DATA_WIDTH % SEG_COUNT) != 0 || SEG_W < 2) begin : g_bad_width
    $fatal(1, "adder_simd_pipe: DATA_WIDTH must split into segments of at least 2 bits");
  end

  // Handshake
  logic v1, v2;
  logic en1, en2;
  logic take;

  assign en2          = !v2 || bus.out_ready;
  assign en1          = !v1 || en2;
  assign bus.in_ready = en1;
  assign take         = bus.in_valid && en1;

  // Stage 1: partitioned carry chain
  lane_mode_e mode_eff;
  logic       lane_cin;

  assign mode_eff = (bus.lane_mode == LM_RSVD) ? LM_X1 : bus.lane_mode;
  assign lane_cin = bus.op_sub ? ~bus.cin : bus.cin;

  logic [SEG_COUNT-1:0][SEG_W:0] seg_ext;

  for (genvar k = 0; k < SEG_COUNT; k++) begin : g_seg
    logic           c_in;
    logic [SEG_W:0] ext;

    if (k == 0) begin : g_first
      assign c_in = lane_cin;
    end else begin : g_chain
      assign c_in = lane_start(mode_eff, k) ? lane_cin : g_seg[k-1].ext[SEG_W];
    end

    adder_simd_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a       (bus.a[k*SEG_W +: SEG_W]),
      .b       (bus.b[k*SEG_W +: SEG_W]),
      .inv_b   (bus.op_sub),
      .cin     (c_in),
      .sum_ext (ext)
    );

    assign seg_ext[k] = ext;
  end

  logic [SEG_COUNT-1:0][SEG_W-1:0] s1_sum;
  logic [SEG_COUNT-1:0]            s1_carry;
  logic [SEG_COUNT-1:0]            s1_a_msb;
  logic [SEG_COUNT-1:0]            s1_b_msb;
  lane_mode_e                      s1_mode;
  logic                            s1_sub;
  logic                            s1_signed;
  logic                            s1_sat;
  logic                            s1_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_sum    <= '0;
      s1_carry  <= '0;
      s1_a_msb  <= '0;
      s1_b_msb  <= '0;
      s1_mode   <= LM_X1;
      s1_sub    <= 1'b0;
      s1_signed <= 1'b0;
      s1_sat    <= 1'b0;
      s1_err    <= 1'b0;
    end else if (en1) begin
      v1 <= bus.in_valid;
      if (take) begin
        for (int k = 0; k < SEG_COUNT; k++) begin
          s1_sum[k]   <= seg_ext[k][SEG_W-1:0];
          s1_carry[k] <= seg_ext[k][SEG_W];
          s1_a_msb[k] <= bus.a[k*SEG_W + SEG_W - 1];
          // MSB of the effective B operand (inverted for subtract).
          s1_b_msb[k] <= bus.b[k*SEG_W + SEG_W - 1] ^ bus.op_sub;
        end
        s1_mode   <= mode_eff;
        s1_sub    <= bus.op_sub;
        s1_signed <= bus.is_signed;
        s1_sat    <= bus.sat_en;
        s1_err    <= (bus.lane_mode == LM_RSVD);
      end
    end
  end

  // Stage 2: lane flags and saturation
  logic [SEG_COUNT-1:0][SEG_W-1:0] s2_sum;
  logic [SEG_COUNT-1:0]            s2_cout;
  logic [SEG_COUNT-1:0]            s2_ovf;

  // Walk segments top-down so each lane's flags are known before its lower segments.
  always_comb begin
    logic lane_ovf;
    logic lane_neg;
    logic is_top;
    logic c;
    logic o;
    s2_sum   = s1_sum;
    s2_cout  = '0;
    s2_ovf   = '0;
    lane_ovf = 1'b0;
    lane_neg = 1'b0;
    is_top   = 1'b0;
    c        = 1'b0;
    o        = 1'b0;
    for (int k = SEG_COUNT - 1; k >= 0; k--) begin
      is_top = lane_top(s1_mode, k);
      if (is_top) begin
        c = s1_carry[k];
        if (s1_signed) begin
          o = (s1_a_msb[k] == s1_b_msb[k]) && (s1_sum[k][SEG_W-1] != s1_a_msb[k]);
        end else begin
          o = s1_sub ? !c : c;
        end
        s2_cout[k] = c;
        s2_ovf[k]  = o;
        lane_ovf   = o;
        lane_neg   = s1_a_msb[k];
      end
      if (s1_sat && lane_ovf) begin
        if (s1_signed) begin
          s2_sum[k] = is_top ? {lane_neg, {(SEG_W-1){!lane_neg}}} : {SEG_W{!lane_neg}};
        end else begin
          s2_sum[k] = {SEG_W{!s1_sub}};
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] sum_q;
  logic [SEG_COUNT-1:0]  cout_q;
  logic [SEG_COUNT-1:0]  ovf_q;
  logic                  sat_hit_q;
  logic                  mode_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2         <= 1'b0;
      sum_q      <= '0;
      cout_q     <= '0;
      ovf_q      <= '0;
      sat_hit_q  <= 1'b0;
      mode_err_q <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        sum_q      <= s2_sum;
        cout_q     <= s2_cout;
        ovf_q      <= s2_ovf;
        sat_hit_q  <= s1_sat && (|s2_ovf);
        mode_err_q <= s1_err;
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.sat_hit   = sat_hit_q;
  assign bus.mode_err  = mode_err_q;

endmodule

// File: tb/tb_adder_simd_pipe.sv
// Randomized and directed checks of adder_simd_pipe against a lane-arithmetic model.
module tb_adder_simd_pipe;
  import adder_simd_pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SC = 4;

  typedef struct {
    logic [DW-1:0] sum;
    logic [SC-1:0] cout;
    logic [SC-1:0] ovf;
    logic          sat_hit;
    logic          mode_err;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_simd_pipe_if #(.DATA_WIDTH(DW), .SEG_COUNT(SC)) bus ();

  adder_simd_pipe #(
    .DATA_WIDTH (DW),
    .SEG_COUNT  (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   chk_lat = 1'b0;
  bit   pending = 1'b0;
  exp_t sb[$];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Lane arithmetic done on plain integers, lane by lane.
  function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic sub,
                                 int mode, logic sgn, logic sat);
    exp_t e;
    int n, lw, m, tseg;
    longint unsigned mask, half, av, bv, res;
    logic [63:0] tmp;
    longint sa, sb2, ex, mx, mn;
    logic c, uovf, sovf, ov;
    m    = (mode == 3) ? 0 : mode;
    n    = 1 << m;
    lw   = DW / n;
    mask = (64'd1 << lw) - 1;
    half = 64'd1 << (lw - 1);
    mx   = longint'(half) - 1;
    mn   = -longint'(half);
    e.sum = '0; e.cout = '0; e.ovf = '0; e.acc = 0;
    for (int i = 0; i < n; i++) begin
      av   = (64'(a) >> (i * lw)) & mask;
      bv   = (64'(b) >> (i * lw)) & mask;
      tseg = (i + 1) * (SC / n) - 1;
      if (!sub) begin
        res  = av + bv + 64'(cin);
        c    = ((res >> lw) & 64'd1) != 0;
        uovf = c;
      end else begin
        c    = av >= (bv + 64'(cin));
        uovf = !c;
        res  = av - bv - 64'(cin);
      end
      sa   = (av >= half) ? longint'(av) - longint'(mask) - 1 : longint'(av);
      sb2  = (bv >= half) ? longint'(bv) - longint'(mask) - 1 : longint'(bv);
      ex   = sub ? sa - sb2 - longint'(cin) : sa + sb2 + longint'(cin);
      sovf = (ex > mx) || (ex < mn);
      ov   = sgn ? sovf : uovf;
      res  = res & mask;
      if (sat && ov) begin
        if (sgn) res = (ex > mx) ? longint'(mx) : (longint'(mn) & mask);
        else     res = sub ? 64'd0 : mask;
      end
      tmp = res << (i * lw);
      e.sum = e.sum | tmp[DW-1:0];
      e.cout[tseg] = c;
      e.ovf[tseg]  = ov;
    end
    e.sat_hit  = sat && (|e.ovf);
    e.mode_err = (mode == 3);
    return e;
  endfunction

  task automatic observe();
    exp_t e;
    cyc++;
    pending = 1'b0;
    check_eq("in_ready", bus.in_ready, (sb.size() < 2) || bus.out_ready);
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", bus.out_valid, 1'b0);
      end else begin
        e = sb[0];
        check_eq("sum", bus.sum, e.sum);
        check_eq("cout", bus.cout, e.cout);
        check_eq("ovf", bus.ovf, e.ovf);
        check_eq("sat_hit", bus.sat_hit, e.sat_hit);
        check_eq("mode_err", bus.mode_err, e.mode_err);
        if (bus.out_ready) begin
          if (chk_lat) check_eq("latency", cyc - e.acc, 2);
          sb.delete(0);
          n_out++;
        end
      end
    end
    if (bus.in_valid) begin
      if (bus.in_ready) begin
        e = model(bus.a, bus.b, bus.cin, bus.op_sub, int'(bus.lane_mode), bus.is_signed,
                  bus.sat_en);
        e.acc = cyc;
        sb.push_back(e);
      end else begin
        pending = 1'b1;
      end
    end
  endtask

  task automatic step();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic set_in(logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic sub, int mode,
                        logic sgn, logic sat);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.op_sub    = sub;
    bus.lane_mode = lane_mode_e'(2'(mode));
    bus.is_signed = sgn;
    bus.sat_en    = sat;
  endtask

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7f7f_7f7f;
      3:       return 32'h8080_8080;
      default: return $urandom();
    endcase
  endfunction

  task automatic set_rand();
    set_in(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 12 && sb.size() > 0; i++) begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
    end
    check_eq(tag, sb.size(), 0);
  endtask

  task automatic check_reset_state(string tag);
    #1;
    check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_sum"}, bus.sum, '0);
    check_eq({tag, "_cout"}, bus.cout, '0);
    check_eq({tag, "_ovf"}, bus.ovf, '0);
    check_eq({tag, "_sat_hit"}, bus.sat_hit, 1'b0);
    check_eq({tag, "_mode_err"}, bus.mode_err, 1'b0);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int  n0;
    int  sent;
    bit  saw_drop;

    rst = 1'b1;
    bus.out_ready = 1'b0;
    set_in('0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("por");

    // Directed vectors
    chk_lat = 1'b1;
    bus.out_ready = 1'b1;
    set_in(32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0); step();
    set_in(32'h7f80_01ff, 32'h01ff_0101, 1'b0, 1'b0, 2, 1'b1, 1'b1); step();
    set_in(32'h0005_0010, 32'h0006_0001, 1'b0, 1'b1, 1, 1'b0, 1'b1); step();
    set_in(32'h0000_ffff, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0, 1'b0); step();
    set_in(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 2, 1'b1, 1'b1); step();
    set_in(32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0, 3, 1'b0, 1'b0); step();
    drain("directed_drain");

    // Backpressure: five back-to-back inputs, out_ready low for cycles 3-6
    chk_lat  = 1'b0;
    n0       = n_out;
    sent     = 0;
    saw_drop = 1'b0;
    for (int t = 0; t < 40 && (sent < 5 || sb.size() > 0); t++) begin
      bus.out_ready = !(t >= 3 && t <= 6);
      if (!pending) begin
        if (sent < 5) begin
          set_rand();
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      step();
      if (pending) saw_drop = 1'b1;
    end
    check_eq("bp_in_ready_drop", saw_drop, 1'b1);
    check_eq("bp_delivered", n_out - n0, 5);
    drain("bp_drain");

    // Reset with two transactions in flight
    bus.out_ready = 1'b1;
    set_rand(); step();
    set_rand(); step();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    sb.delete();
    pending = 1'b0;
    check_reset_state("midrst");

    // Reserved mode after reset
    chk_lat = 1'b1;
    bus.out_ready = 1'b1;
    set_in(32'h1234_ffff, 32'h0000_0001, 1'b0, 1'b0, 3, 1'b0, 1'b0); step();
    drain("rsvd_drain");

    // Random traffic with random backpressure
    chk_lat = 1'b0;
    for (int t = 0; t < 400; t++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) set_rand();
        else bus.in_valid = 1'b0;
      end
      step();
    end
    drain("rand_bp_drain");

    // Random streaming with no backpressure: fixed two-cycle latency
    chk_lat = 1'b1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      set_rand();
      step();
    end
    drain("stream_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_simd_pipe.md
Name: adder_simd_pipe

Overview:
- Next-generation adder IP: runtime-partitioned SIMD add/subtract with 1, 2 or 4 lanes across a DATA_WIDTH datapath.
- Per-lane signed/unsigned overflow, per-lane saturation, per-lane carry flags.
- Fixed 2-stage pipeline with valid/ready backpressure; full throughput when not stalled.
- Sits wherever the scalar adder IP sits, but serves packed-vector datapaths.

Parameters:
DATA_WIDTH, 32, total operand width; must be a multiple of SEG_COUNT, with segment width >= 2 (elaboration $fatal otherwise)
SEG_COUNT, 4, number of segments; fixed at 4 (elaboration $fatal otherwise)
SEG_W, DATA_WIDTH/SEG_COUNT, derived localparam, bits per segment

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
a  in  DATA_WIDTH  operand A (packed lanes, lane 0 in LSBs)
b  in  DATA_WIDTH  operand B
cin  in  1  carry/borrow-in, applied to every lane
op_sub  in  1  0 = A+B+cin, 1 = A-B-cin
lane_mode  in  2  0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes, 3 = reserved
is_signed  in  1  lanes interpreted as two's complement
sat_en  in  1  clamp overflowing lanes
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  DATA_WIDTH  packed lane results
cout  out  SEG_COUNT  raw carry-out of each lane, reported at the lane's top segment index; other bits 0
ovf  out  SEG_COUNT  lane overflow (signed or unsigned rule), same indexing as cout
sat_hit  out  1  OR of ovf when sat_en=1; else 0
mode_err  out  1  result was issued with lane_mode=3

Behaviour:
- Reset: synchronous, sampled on the clk rising edge.
  - Stage valids v1 and v2 clear.
  - out_valid=0, sum=0, cout=0, ovf=0, sat_hit=0, mode_err=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation drops all in-flight transactions.
- Handshake: transfer occurs when valid && ready.
  - en2 = !v2 || out_ready
  - en1 = !v1 || en2
  - in_ready = en1 (combinational from out_ready; no input-to-output combinational data path)
  - While stalled (out_valid && !out_ready), outputs hold stable.
  - No bubbles: back-to-back accepted inputs emerge on consecutive cycles.
  - Latency: result appears on out_valid exactly 2 cycles after acceptance when unstalled.
- Stage 1 (add):
  - Per segment k: a_seg + (op_sub ? ~b_seg : b_seg) + c_in[k], computed at width SEG_W+1.
  - c_in[k] is the lane carry-in when segment k starts a lane, otherwise the carry from segment k-1.
  - Lane carry-in = op_sub ? ~cin : cin.
  - Lane starts: mode 0 → segment 0; mode 1 → segments 0 and 2; mode 2 → all segments.
  - Register segment sums, carries, operand lane MSBs, and controls.
- Stage 2 (flags/saturate):
  - Per lane: top = lane's top segment; c = carry out of top.
  - Signed: ovf = (a_msb == b'_msb) && (s_msb != a_msb), where b' is the inverted B for subtract.
  - Unsigned add: ovf = c. Unsigned sub: ovf = !c (borrow).
  - cout = c in all cases.
  - Saturation (sat_en && ovf):
    - signed: clamp to max positive if a_msb==0, else min negative, at lane width;
    - unsigned add: all ones;
    - unsigned sub: zero.
  - Non-overflowing lanes pass through unmodified.
- lane_mode=3 is processed as mode 0 with mode_err=1 for that result only.
- Controls are sampled per transaction; mode may change every cycle.
- Carries never cross lane boundaries.

Decomposition:
- adder_pkg gains:
  - lane_mode enum: LM_X1=0, LM_X2=1, LM_X4=2, LM_RSVD=3
  - function lane_start(mode, seg), returning a bit
  - function lane_top(mode, seg), returning a bit
- One sub-module, adder_simd_seg: a combinational SEG_W-bit adder slice (inputs a, b, inv_b, cin; output SEG_W+1 sum_ext).
  - Instantiated SEG_COUNT times in stage 1.

Test Plan:
- DW=32, mode 0, add, unsigned, a=FFFFFFFF, b=1, cin=0, sat_en=0 → 2 cycles later: sum=0, cout=4'b1000, ovf=4'b1000, sat_hit=0.
- Mode 2, signed, sat_en=1, add, a=7F_80_01_FF, b=01_FF_01_01 → sum=7F_80_02_00, ovf=4'b1100, sat_hit=1.
- Mode 1, unsigned, sub, sat_en=1, a=0005_0010, b=0006_0001, cin=0 → sum=0000_000F, ovf=4'b1000.
- Mode 1, add, a=0000_FFFF, b=0000_0001 → sum=0000_0000, cout=4'b0010; no carry into the upper lane.
- Backpressure: stream 5 back-to-back inputs, hold out_ready=0 for cycles 3-6.
  - in_ready drops once both stages are full.
  - Outputs hold stable while stalled.
  - All 5 results delivered in order; none lost or duplicated.
- Reset asserted while 2 transactions are in flight → next cycle out_valid=0, all outputs 0, in_ready=1; lane_mode=3 input yields mode_err=1 and a mode-0 result.
